// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the GCD arbiter: FSM encoding, requester ids and the
// default WAIT timeout.
package gcd_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StWait   = 3'd2,
    StFix    = 3'd3,
    StResp   = 3'd4
  } state_e;

  localparam logic KEYGEN = 1'b0;
  localparam logic CRT    = 1'b1;

  function automatic int unsigned default_timeout(input int unsigned width);
    return 16 * width * width;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_pick2.sv
// Two-way round-robin selector: the favoured requester wins when valid,
// otherwise the other one.
module gcd_arbiter_rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_fav,
  output logic [1:0] o_grant,
  output logic       o_gid
);

  always_comb begin
    o_gid   = i_valid[i_fav] ? i_fav : ~i_fav;
    o_grant = 2'b00;
    if (|i_valid) begin
      o_grant[o_gid] = 1'b1;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one extended-GCD core between key generation
// and CRT setup; returns gcd and b^-1 mod a normalised to [0, a).
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = default_timeout(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a0,
  input  logic [2*WIDTH-1:0] req_b0,
  input  logic [2*WIDTH-1:0] req_a1,
  input  logic [2*WIDTH-1:0] req_b1,
  output logic [1:0]         resp_valid,
  output logic [2*WIDTH-1:0] resp_gcd,
  output logic [2*WIDTH-1:0] resp_inv,
  output logic               resp_inv_ok,
  output logic               resp_err,
  output logic               gcd_start,
  output logic [2*WIDTH-1:0] gcd_a,
  output logic [2*WIDTH-1:0] gcd_b,
  input  logic [2*WIDTH-1:0] gcd_result,
  input  logic [2*WIDTH-1:0] gcd_s,
  input  logic [2*WIDTH-1:0] gcd_t,
  input  logic               gcd_finish
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_e           r_state;
  logic             r_rr;
  logic             r_owner;
  logic [W2-1:0]    r_a, r_b, r_gcd, r_t;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_resp_valid;
  logic [W2-1:0]    r_resp_gcd, r_resp_inv;
  logic             r_inv_ok, r_err, r_start;

  logic [1:0]    w_grant;
  logic          w_gid;
  logic [W2-1:0] w_acc_a, w_acc_b, w_fix_inv;
  logic          w_bad, w_fix_ok, w_timeout;
  logic          w_unused_s;

  gcd_arbiter_rr_pick2 u_pick (
    .i_valid (req_valid),
    .i_fav   (r_rr),
    .o_grant (w_grant),
    .o_gid   (w_gid)
  );

  assign req_ready = (r_state == StIdle) ? w_grant : 2'b00;
  assign w_acc_a   = w_gid ? req_a1 : req_a0;
  assign w_acc_b   = w_gid ? req_b1 : req_b0;
  assign w_bad     = (w_acc_b == '0) || (w_acc_a < w_acc_b);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_fix_ok  = (r_gcd == W2'(1));
  // Negative Bezout coefficient wraps into [0, a); carry out is dropped.
  assign w_fix_inv = r_t[W2-1] ? (r_t + r_a) : r_t;
  // The s coefficient is not needed to form b^-1 mod a.
  assign w_unused_s = ^gcd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_rr         <= KEYGEN;
      r_owner      <= KEYGEN;
      r_a          <= '0;
      r_b          <= '0;
      r_gcd        <= '0;
      r_t          <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 2'b00;
      r_resp_gcd   <= '0;
      r_resp_inv   <= '0;
      r_inv_ok     <= 1'b0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_resp_valid <= 2'b00;
      unique case (r_state)
        StIdle: begin
          if (|req_valid) begin
            r_owner <= w_gid;
            r_a     <= w_acc_a;
            r_b     <= w_acc_b;
            if (w_bad) begin
              r_err        <= 1'b1;
              r_resp_gcd   <= '0;
              r_resp_inv   <= '0;
              r_inv_ok     <= 1'b0;
              r_resp_valid <= w_grant;
              r_state      <= StResp;
            end else begin
              r_start <= 1'b1;
              r_state <= StLaunch;
            end
          end
        end
        StLaunch: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (gcd_finish) begin
            r_gcd   <= gcd_result;
            r_t     <= gcd_t;
            r_state <= StFix;
          end else if (w_timeout) begin
            r_gcd        <= '0;
            r_t          <= '0;
            r_err        <= 1'b1;
            r_resp_gcd   <= '0;
            r_resp_inv   <= '0;
            r_inv_ok     <= 1'b0;
            r_resp_valid <= {r_owner, ~r_owner};
            r_state      <= StResp;
          end
        end
        StFix: begin
          r_err        <= 1'b0;
          r_inv_ok     <= w_fix_ok;
          r_resp_gcd   <= r_gcd;
          r_resp_inv   <= w_fix_ok ? w_fix_inv : '0;
          r_resp_valid <= {r_owner, ~r_owner};
          r_state      <= StResp;
        end
        StResp: begin
          r_rr    <= ~r_owner;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_gcd    = r_resp_gcd;
  assign resp_inv    = r_resp_inv;
  assign resp_inv_ok = r_inv_ok;
  assign resp_err    = r_err;
  assign gcd_start   = r_start;
  assign gcd_a       = r_a;
  assign gcd_b       = r_b;

endmodule
